alu_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares the single 4-bit ALU (AND/NOT/OR/XOR/SHL/SUM/SUB/TWOS) between two requesters. Each requester presents an opcode and two nibble operands over a valid/ready handshake. The block drives the ALU's operand and opcode inputs, waits a programmable settle time, captures the result and carry, and returns them on a per-requester response handshake. It sits between the two operand sources (accumulator paths A/B) and the combinational ALU instance.

---
 rtl/alu_arbiter.sv | 95 +++++++++
 tb/tb_alu_arbiter.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - round-robin arbiter/sequencer sharing one 4-bit ALU between two requesters
module alu_arbiter #(
  parameter int ALU_LAT = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req0_valid,
  output logic       req0_ready,
  input  logic [2:0] req0_op,
  input  logic [3:0] req0_a,
  input  logic [3:0] req0_b,
  input  logic       req1_valid,
  output logic       req1_ready,
  input  logic [2:0] req1_op,
  input  logic [3:0] req1_a,
  input  logic [3:0] req1_b,
  output logic       rsp0_valid,
  input  logic       rsp0_ready,
  output logic       rsp1_valid,
  input  logic       rsp1_ready,
  output logic [3:0] rsp_data,
  output logic       rsp_carry,
  output logic [3:0] alu_x,
  output logic [3:0] alu_y,
  output logic [2:0] alu_op,
  input  logic [3:0] alu_out,
  input  logic       alu_carry
);

  typedef enum logic [1:0] {IDLE, ISSUE, RESPOND} state_t;

  state_t     state;
  logic       last_grant;
  logic       gnt;
  logic [3:0] cnt;
  logic       pick1;
  logic       rsp_done;

  // Requester 1 wins when it is alone or when requester 0 was served last.
  assign pick1      = req1_valid && (!req0_valid || !last_grant);
  assign req0_ready = !reset && (state == IDLE) && req0_valid && !pick1;
  assign req1_ready = !reset && (state == IDLE) && pick1;
  assign rsp_done   = (rsp0_valid && rsp0_ready) || (rsp1_valid && rsp1_ready);

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      gnt        <= 1'b0;
      cnt        <= 4'd0;
      rsp0_valid <= 1'b0;
      rsp1_valid <= 1'b0;
      rsp_data   <= 4'd0;
      rsp_carry  <= 1'b0;
      alu_x      <= 4'd0;
      alu_y      <= 4'd0;
      alu_op     <= 3'd0;
    end else begin
      case (state)
        IDLE: begin
          if (req0_valid || req1_valid) begin
            gnt    <= pick1;
            alu_op <= pick1 ? req1_op : req0_op;
            alu_x  <= pick1 ? req1_a  : req0_a;
            alu_y  <= pick1 ? req1_b  : req0_b;
            cnt    <= 4'(ALU_LAT - 1);
            state  <= ISSUE;
          end
        end
        ISSUE: begin
          // Operands stay on the ALU until the settle count expires.
          if (cnt == 4'd0) begin
            rsp_data   <= alu_out;
            rsp_carry  <= alu_carry;
            rsp0_valid <= !gnt;
            rsp1_valid <= gnt;
            state      <= RESPOND;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESPOND: begin
          if (rsp_done) begin
            rsp0_valid <= 1'b0;
            rsp1_valid <= 1'b0;
            last_grant <= gnt;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - scoreboard bench for alu_arbiter with a behavioural ALU
module tb_alu_arbiter;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic       req0_valid = 1'b0, req1_valid = 1'b0, req0_ready, req1_ready;
  logic [2:0] req0_op = 3'd0, req1_op = 3'd0;
  logic [3:0] req0_a = 4'd0, req0_b = 4'd0, req1_a = 4'd0, req1_b = 4'd0;
  logic       rsp0_valid, rsp1_valid, rsp0_ready = 1'b1, rsp1_ready = 1'b1;
  logic [3:0] rsp_data, alu_x, alu_y, alu_out;
  logic       rsp_carry, alu_carry;
  logic [2:0] alu_op;

  logic       q_req0_valid = 1'b0, q_req0_ready, q_req1_ready;
  logic       q_req1_valid = 1'b0;
  logic [2:0] q_req0_op = 3'd0, q_req1_op = 3'd0;
  logic [3:0] q_req0_a = 4'd0, q_req0_b = 4'd0, q_req1_a = 4'd0, q_req1_b = 4'd0;
  logic       q_rsp0_valid, q_rsp1_valid, q_rsp0_ready = 1'b1, q_rsp1_ready = 1'b1;
  logic [3:0] q_rsp_data, q_alu_x, q_alu_y, q_alu_out;
  logic       q_rsp_carry, q_alu_carry;
  logic [2:0] q_alu_op;

  // Returns {carry, out}; SUB carry is the borrow.
  function automatic logic [4:0] alu_ref(input logic [2:0] op, input logic [3:0] x, input logic [3:0] y);
    case (op)
      3'd0:    alu_ref = {1'b0, x & y};
      3'd1:    alu_ref = {1'b0, ~x};
      3'd2:    alu_ref = {1'b0, x | y};
      3'd3:    alu_ref = {1'b0, x ^ y};
      3'd4:    alu_ref = {x, 1'b0};
      3'd5:    alu_ref = {1'b0, x} + {1'b0, y};
      3'd6:    alu_ref = {1'b0, x} - {1'b0, y};
      default: alu_ref = {1'b0, ~x} + 5'd1;
    endcase
  endfunction

  assign {alu_carry, alu_out}     = alu_ref(alu_op, alu_x, alu_y);
  assign {q_alu_carry, q_alu_out} = alu_ref(q_alu_op, q_alu_x, q_alu_y);

  alu_arbiter #(.ALU_LAT(1)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
    .rsp_data(rsp_data), .rsp_carry(rsp_carry),
    .alu_x(alu_x), .alu_y(alu_y), .alu_op(alu_op), .alu_out(alu_out), .alu_carry(alu_carry)
  );

  alu_arbiter #(.ALU_LAT(4)) dut4 (
    .clk(clk), .reset(reset),
    .req0_valid(q_req0_valid), .req0_ready(q_req0_ready), .req0_op(q_req0_op), .req0_a(q_req0_a), .req0_b(q_req0_b),
    .req1_valid(q_req1_valid), .req1_ready(q_req1_ready), .req1_op(q_req1_op), .req1_a(q_req1_a), .req1_b(q_req1_b),
    .rsp0_valid(q_rsp0_valid), .rsp0_ready(q_rsp0_ready), .rsp1_valid(q_rsp1_valid), .rsp1_ready(q_rsp1_ready),
    .rsp_data(q_rsp_data), .rsp_carry(q_rsp_carry),
    .alu_x(q_alu_x), .alu_y(q_alu_y), .alu_op(q_alu_op), .alu_out(q_alu_out), .alu_carry(q_alu_carry)
  );

  typedef struct packed { logic id; logic [3:0] d; logic c; } exp_t;
  exp_t sbq[$];
  exp_t pend[2];

  int passed = 0, total = 0, failed = 0;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic timeout_fail(input string tag);
    total++;
    failed++;
    $error("FAIL %s observed=timeout expected=event", tag);
  endtask

  task automatic wait_cycle();
    @(negedge clk);
    #1;
  endtask

  task automatic present(input logic id, input logic [2:0] op, input logic [3:0] a, input logic [3:0] b,
                         input logic [3:0] ed, input logic ec);
    pend[id] = {id, ed, ec};
    if (id) begin
      req1_op = op; req1_a = a; req1_b = b; req1_valid = 1'b1;
    end else begin
      req0_op = op; req0_a = a; req0_b = b; req0_valid = 1'b1;
    end
  endtask

  task automatic accept(input logic id, output int t);
    t = -1;
    for (int i = 0; i < 30; i++) begin
      #1;
      if ((id ? req1_ready : req0_ready) === 1'b1) begin
        sbq.push_back(pend[id]);
        t = cyc;
        return;
      end
      wait_cycle();
    end
    timeout_fail("accept");
  endtask

  task automatic accept_any(output logic g, output int t);
    t = -1;
    g = 1'b0;
    for (int i = 0; i < 30; i++) begin
      #1;
      if (req0_ready === 1'b1 || req1_ready === 1'b1) begin
        check("one_ready", {15'd0, req0_ready & req1_ready}, 16'd0);
        g = req1_ready;
        sbq.push_back(pend[g]);
        t = cyc;
        return;
      end
      wait_cycle();
    end
    timeout_fail("accept_any");
  endtask

  task automatic collect(output int t);
    exp_t e;
    t = -1;
    for (int i = 0; i < 30; i++) begin
      #1;
      if (rsp0_valid === 1'b1 || rsp1_valid === 1'b1) begin
        t = cyc;
        rsp0_ready = 1'b1;
        rsp1_ready = 1'b1;
        if (sbq.size() == 0) begin
          timeout_fail("sb_empty");
          return;
        end
        e = sbq.pop_front();
        check("rsp_who", {14'd0, rsp1_valid, rsp0_valid}, e.id ? 16'd2 : 16'd1);
        check("rsp_data", {12'd0, rsp_data}, {12'd0, e.d});
        check("rsp_carry", {15'd0, rsp_carry}, {15'd0, e.c});
        return;
      end
      wait_cycle();
    end
    timeout_fail("collect");
  endtask

  task automatic one_op(input logic id, input logic [2:0] op, input logic [3:0] a, input logic [3:0] b,
                        input logic [3:0] ed, input logic ec, output int lat);
    int ta, tr;
    present(id, op, a, b, ed, ec);
    accept(id, ta);
    wait_cycle();
    if (id) req1_valid = 1'b0; else req0_valid = 1'b0;
    collect(tr);
    lat = tr - ta;
    wait_cycle();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=running expected=finished");
    $fatal(1);
  end

  initial begin
    int ta, tr, th, lat, held;
    logic g;
    exp_t e;

    wait_cycle();
    wait_cycle();
    check("reset_rsp", {rsp0_valid, rsp1_valid, rsp_data, rsp_carry}, 16'd0);
    check("reset_alu", {alu_x, alu_y, alu_op}, 16'd0);
    check("reset_lat4", {q_rsp0_valid, q_alu_x, q_alu_y, q_alu_op}, 16'd0);
    reset = 1'b0;
    wait_cycle();
    check("idle_ready", {14'd0, req0_ready, req1_ready}, 16'd0);

    // ALU_LAT=4: SHL 0011 -> 0110, operands held for four ISSUE cycles
    q_req0_op = 3'd4; q_req0_a = 4'd3; q_req0_b = 4'd0; q_req0_valid = 1'b1;
    #1;
    check("lat4_ready", {15'd0, q_req0_ready}, 16'd1);
    ta = cyc;
    sbq.push_back({1'b0, 4'd6, 1'b0});
    wait_cycle();
    q_req0_valid = 1'b0;
    held = 0;
    tr = -1;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (q_rsp0_valid === 1'b1) begin
        tr = cyc;
        break;
      end
      if (q_alu_op === 3'b100 && q_alu_x === 4'd3) held++;
      wait_cycle();
    end
    if (tr < 0) timeout_fail("lat4_rsp");
    else begin
      e = sbq.pop_front();
      check("lat4_latency", 16'(tr - ta), 16'd5);
      check("lat4_held", 16'(held), 16'd4);
      check("lat4_data", {11'd0, q_rsp_data, q_rsp_carry}, {11'd0, e.d, e.c});
      check("lat4_rsp1", {15'd0, q_rsp1_valid}, 16'd0);
    end
    wait_cycle();
    wait_cycle();

    // single request, ALU_LAT=1
    present(1'b0, 3'd5, 4'd3, 4'd5, 4'd8, 1'b0);
    accept(1'b0, ta);
    check("single_req1_ready", {15'd0, req1_ready}, 16'd0);
    wait_cycle();
    req0_valid = 1'b0;
    collect(tr);
    check("single_latency", 16'(tr - ta), 16'd2);
    wait_cycle();

    one_op(1'b1, 3'd5, 4'hF, 4'hE, 4'hD, 1'b1, lat);
    one_op(1'b1, 3'd7, 4'h3, 4'h0, 4'hD, 1'b0, lat);
    check("carry_latency", 16'(lat), 16'd2);

    // contention from a known tie state: AND by req0, XOR by req1
    present(1'b0, 3'd0, 4'hF, 4'h6, 4'h6, 1'b0);
    present(1'b1, 3'd3, 4'hA, 4'h5, 4'hF, 1'b0);
    accept(1'b0, ta);
    check("tie_req1_ready", {15'd0, req1_ready}, 16'd0);
    wait_cycle();
    req0_valid = 1'b0;
    collect(tr);
    wait_cycle();
    accept(1'b1, ta);
    wait_cycle();
    req1_valid = 1'b0;
    collect(tr);
    wait_cycle();

    // fairness with both requesters continuously valid
    present(1'b0, 3'd2, 4'h9, 4'h4, 4'hD, 1'b0);
    present(1'b1, 3'd6, 4'h7, 4'h9, 4'hE, 1'b1);
    for (int k = 0; k < 4; k++) begin
      accept_any(g, ta);
      check("alt_grant", {15'd0, g}, 16'(k % 2));
      wait_cycle();
      if (k < 2) begin
        if (g) present(1'b1, 3'd1, 4'h5, 4'h0, 4'hA, 1'b0);
        else   present(1'b0, 3'd6, 4'h9, 4'h7, 4'h2, 1'b0);
      end else if (g) req1_valid = 1'b0;
      else req0_valid = 1'b0;
      collect(tr);
      wait_cycle();
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    wait_cycle();

    // response backpressure on requester 0 while requester 1 waits
    present(1'b0, 3'd5, 4'h2, 4'h2, 4'h4, 1'b0);
    accept(1'b0, ta);
    wait_cycle();
    req0_valid = 1'b0;
    rsp0_ready = 1'b0;
    present(1'b1, 3'd0, 4'hC, 4'hA, 4'h8, 1'b0);
    tr = -1;
    for (int i = 0; i < 30; i++) begin
      #1;
      if (rsp0_valid === 1'b1) begin
        tr = cyc;
        break;
      end
      wait_cycle();
    end
    if (tr < 0) timeout_fail("bp_valid");
    for (int i = 0; i < 5; i++) begin
      check("bp_hold", {10'd0, rsp0_valid, req1_ready, rsp_data}, {10'd0, 1'b1, 1'b0, 4'h4});
      wait_cycle();
    end
    collect(th);
    wait_cycle();
    accept(1'b1, ta);
    check("bp_next_grant", 16'(ta - th), 16'd1);
    wait_cycle();
    req1_valid = 1'b0;
    collect(tr);
    wait_cycle();

    // serve req0 so last_grant is 0, then reset during a req1 ISSUE
    one_op(1'b0, 3'd4, 4'h5, 4'h0, 4'hA, 1'b0, lat);
    present(1'b1, 3'd5, 4'h1, 4'h1, 4'h2, 1'b0);
    accept(1'b1, ta);
    wait_cycle();
    req1_valid = 1'b0;
    check("mid_issue_alu", {alu_x, alu_y, 5'd0, alu_op}, {4'h1, 4'h1, 5'd0, 3'd5});
    reset = 1'b1;
    wait_cycle();
    reset = 1'b0;
    void'(sbq.pop_back());
    check("rst_rsp", {rsp0_valid, rsp1_valid, rsp_data, rsp_carry}, 16'd0);
    check("rst_alu", {alu_x, alu_y, alu_op}, 16'd0);
    for (int i = 0; i < 3; i++) begin
      wait_cycle();
      check("rst_no_rsp", {14'd0, rsp0_valid, rsp1_valid}, 16'd0);
    end
    present(1'b0, 3'd3, 4'h6, 4'h3, 4'h5, 1'b0);
    present(1'b1, 3'd2, 4'h8, 4'h1, 4'h9, 1'b0);
    accept_any(g, ta);
    check("rst_tie_grant", {15'd0, g}, 16'd0);
    wait_cycle();
    req0_valid = 1'b0;
    collect(tr);
    wait_cycle();
    accept(1'b1, ta);
    wait_cycle();
    req1_valid = 1'b0;
    collect(tr);
    wait_cycle();
    check("sb_drained", 16'(sbq.size()), 16'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
